// File: rtl/vx_tcu_fedp_ctrl.sv
// Credit-based issue/response controller for a fixed-latency dot-product
// pipeline. Each issue is tracked through a LATENCY-deep valid+tag shift
// register; when it reaches the tail the pipeline result is captured into a
// DEPTH-entry response FIFO. Credits (in flight + buffered) cap outstanding
// work at DEPTH, so the pipeline never needs to stall.
module vx_tcu_fedp_ctrl #(
    parameter int LATENCY   = 10,
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 req_ready,
    output logic                 fedp_enable,
    input  logic [31:0]          fedp_d_val,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    input  logic                 rsp_ready,
    output logic                 busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic                 r_run;
    logic [CW-1:0]        r_credit;
    logic [LATENCY-1:0]   r_sr_vld;
    logic [TAG_WIDTH-1:0] r_sr_tag [LATENCY];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_fifo_cnt;
    logic [31:0]          r_mem_data [DEPTH];
    logic [TAG_WIDTH-1:0] r_mem_tag  [DEPTH];

    logic                 w_issue;
    logic                 w_pop;
    logic                 w_tail_vld;
    logic [TAG_WIDTH-1:0] w_tail_tag;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // r_run is cleared by reset and set on the first clock after release,
    // which gates req_ready and fedp_enable low throughout reset.
    assign req_ready   = r_run && (r_credit < CW'(DEPTH));
    assign fedp_enable = r_run;
    assign busy        = (r_credit != '0);
    assign rsp_valid   = (r_fifo_cnt != '0);

    assign w_issue    = req_valid && req_ready;
    assign w_pop      = rsp_valid && rsp_ready;
    assign w_tail_vld = r_sr_vld[LATENCY-1];
    assign w_tail_tag = r_sr_tag[LATENCY-1];

    // Head read is combinational so an entry written into an empty FIFO is
    // presented on the very next cycle.
    assign rsp_data = r_mem_data[r_rd_ptr];
    assign rsp_tag  = r_mem_tag[r_rd_ptr];

    // Run flag: low in reset, high from the first clock afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // Credit counter: +1 on issue, -1 on pop, hold when both or neither.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit <= '0;
        end else if (w_issue && !w_pop) begin
            r_credit <= r_credit + CW'(1);
        end else if (!w_issue && w_pop) begin
            r_credit <= r_credit - CW'(1);
        end
    end

    // Shift-register head stage: valid loaded with the issue strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sr_vld[0] <= 1'b0;
        else       r_sr_vld[0] <= w_issue;
    end

    // Tags need no reset; they are only meaningful alongside a valid bit.
    always_ff @(posedge clk) begin
        r_sr_tag[0] <= req_tag;
    end

    // Remaining shift stages advance unconditionally every cycle.
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
            // Valid bit of stage gi.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) r_sr_vld[gi] <= 1'b0;
                else       r_sr_vld[gi] <= r_sr_vld[gi-1];
            end
            // Tag of stage gi.
            always_ff @(posedge clk) begin
                r_sr_tag[gi] <= r_sr_tag[gi-1];
            end
        end
    endgenerate

    // FIFO pointers and occupancy; write and pop may coincide at any level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_tail_vld) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)      r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_tail_vld && !w_pop)      r_fifo_cnt <= r_fifo_cnt + CW'(1);
            else if (!w_tail_vld && w_pop) r_fifo_cnt <= r_fifo_cnt - CW'(1);
        end
    end

    // FIFO storage: capture the pipeline result when the tail is valid.
    always_ff @(posedge clk) begin
        if (w_tail_vld) begin
            r_mem_data[r_wr_ptr] <= fedp_d_val;
            r_mem_tag[r_wr_ptr]  <= w_tail_tag;
        end
    end

    // The credit scheme must make a write into a full FIFO impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(w_tail_vld && (r_fifo_cnt == CW'(DEPTH)) && !w_pop));

endmodule

// File: tb/tb_vx_tcu_fedp_ctrl.sv
// Self-checking bench for vx_tcu_fedp_ctrl (LATENCY=10, DEPTH=4).
// A queue-based reference model tracks outstanding requests by issue cycle
// and buffered results; a vector table and hand sequences add fixed checks.
module tb_vx_tcu_fedp_ctrl;

    localparam int LAT = 10;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [7:0]  req_tag;
    logic        req_ready;
    logic        fedp_enable;
    logic [31:0] fedp_d_val;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [7:0]  rsp_tag;
    logic        rsp_ready;
    logic        busy;

    vx_tcu_fedp_ctrl #(.LATENCY(LAT), .DEPTH(DEP), .TAG_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
        .fedp_enable(fedp_enable), .fedp_d_val(fedp_d_val),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    typedef struct { int cyc; logic [7:0] tag; } inf_t;
    typedef struct { logic [31:0] d; logic [7:0] tag; } rsp_t;
    inf_t inf_q[$];
    rsp_t fq[$];
    bit   m_run = 0;
    int   m_cyc = 0;

    // DUT values sampled in the latest step
    logic        s_ready, s_rvalid, s_busy, s_en;
    logic [31:0] s_data;
    logic [7:0]  s_tag;

    typedef struct {
        logic rv; logic [7:0] tag; logic [31:0] d; logic rr;
        logic e_ready; logic e_rvalid; logic e_busy;
        logic [31:0] e_data; logic [7:0] e_tag;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, m_cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, compare at negedge against the model, advance.
    task automatic step(input logic rv, input logic [7:0] tg, input logic [31:0] d,
                        input logic rr, input logic rs);
        bit   m_ready, m_rv, m_busy, issue, pop;
        rsp_t r;
        inf_t f;
        req_valid = rv; req_tag = tg; fedp_d_val = d; rsp_ready = rr; reset = rs;
        if (rs) begin
            inf_q.delete(); fq.delete(); m_run = 0;
        end
        @(negedge clk);
        m_ready = m_run && ((inf_q.size() + fq.size()) < DEP);
        m_rv    = fq.size() != 0;
        m_busy  = (inf_q.size() + fq.size()) != 0;
        s_ready = req_ready; s_rvalid = rsp_valid; s_busy = busy; s_en = fedp_enable;
        s_data = rsp_data; s_tag = rsp_tag;
        chk("req_ready", {31'b0, req_ready}, {31'b0, m_ready});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rv});
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("fedp_enable", {31'b0, fedp_enable}, {31'b0, m_run});
        if (m_rv) begin
            chk("rsp_data", rsp_data, fq[0].d);
            chk("rsp_tag", {24'b0, rsp_tag}, {24'b0, fq[0].tag});
        end
        issue = rv && m_ready;
        pop   = m_rv && rr;
        @(posedge clk);
        if (rs) begin
            m_run = 0;
        end else begin
            m_run = 1;
            if (pop) void'(fq.pop_front());
            if (inf_q.size() > 0 && inf_q[0].cyc + LAT == m_cyc) begin
                r.d = d; r.tag = inf_q[0].tag;
                fq.push_back(r);
                void'(inf_q.pop_front());
            end
            if (issue) begin
                f.cyc = m_cyc; f.tag = tg;
                inf_q.push_back(f);
            end
        end
        m_cyc++;
        #1;
    endtask

    task automatic do_reset();
        step(0, 8'h0, 32'h0, 0, 1);
        step(0, 8'h0, 32'h0, 0, 1);
        step(0, 8'h0, 32'h0, 0, 0);   // release; run flag sets at this edge
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(0, 8'h0, 32'hBAD00000 + i, rr, 0);
    endtask

    initial begin
        int   nt, nout;
        logic [7:0] etag;

        reset = 1; req_valid = 0; req_tag = 0; fedp_d_val = 0; rsp_ready = 0;
        #1;

        // Single issue: tag 5A, result 3F800000 at cycle 10, popped at cycle 11
        for (int i = 0; i < 13; i++)
            tbl[i] = '{1'b0, 8'h00, 32'hDEAD0000 + i, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'h0};
        tbl[0].rv = 1'b1; tbl[0].tag = 8'h5A; tbl[0].e_busy = 1'b0;
        tbl[10].d = 32'h3F800000;
        tbl[11].rr = 1'b1; tbl[11].e_rvalid = 1'b1;
        tbl[11].e_data = 32'h3F800000; tbl[11].e_tag = 8'h5A;
        tbl[12].e_busy = 1'b0;

        // Reset state
        step(0, 8'h0, 32'h0, 0, 1);
        chk("rst_req_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, s_rvalid}, 32'd0);
        chk("rst_busy", {31'b0, s_busy}, 32'd0);
        chk("rst_fedp_en", {31'b0, s_en}, 32'd0);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rv, tbl[i].tag, tbl[i].d, tbl[i].rr, 0);
            chk($sformatf("tbl%0d_ready", i), {31'b0, s_ready}, {31'b0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_rvalid", i), {31'b0, s_rvalid}, {31'b0, tbl[i].e_rvalid});
            chk($sformatf("tbl%0d_busy", i), {31'b0, s_busy}, {31'b0, tbl[i].e_busy});
            if (tbl[i].e_rvalid) begin
                chk($sformatf("tbl%0d_data", i), s_data, tbl[i].e_data);
                chk($sformatf("tbl%0d_tag", i), {24'b0, s_tag}, {24'b0, tbl[i].e_tag});
            end
            $display("tbl %0d: ready=%b rsp_valid=%b busy=%b tag=%h", i, s_ready, s_rvalid, s_busy, s_tag);
        end

        // Fill: req_valid held, rsp_ready low -> four issues then stall
        do_reset();
        nt = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 8'h10 + i[7:0], 32'h5000 + i, 0, 0);
            chk($sformatf("fill%0d_ready", i), {31'b0, s_ready}, {31'b0, (i < 4)});
            if (s_ready) nt++;
            if (i == 14) begin
                chk("full_rvalid", {31'b0, s_rvalid}, 32'd1);
                chk("full_head_tag", {24'b0, s_tag}, 32'h10);
            end
        end
        chk("fill_issues", nt, 4);
        $display("fill: %0d issues", nt);
        // One pop while full, then exactly one issue refills the credit
        step(1, 8'h40, 32'h0, 1, 0);
        chk("pop_ready_before", {31'b0, s_ready}, 32'd0);
        step(1, 8'h41, 32'h0, 0, 0);
        chk("pop_ready_after", {31'b0, s_ready}, 32'd1);
        chk("pop_new_head", {24'b0, s_tag}, 32'h11);
        step(1, 8'h42, 32'h0, 0, 0);
        chk("refill_ready", {31'b0, s_ready}, 32'd0);
        $display("pop-while-full: head=%h ready=%b", s_tag, s_ready);

        // Continuous issue with rsp_ready=1: responses in issue order
        do_reset();
        nt = 0; nout = 0; etag = 8'h00;
        for (int i = 0; i < 60; i++) begin
            step(1, nt[7:0], 32'hC0DE0000 + i, 1, 0);
            if (s_ready) nt++;
            if (s_rvalid) begin
                chk("stream_tag", {24'b0, s_tag}, {24'b0, etag});
                etag++; nout++;
            end
        end
        chk("stream_count_ok", {31'b0, (nout >= 12)}, 32'd1);
        $display("stream: %0d issued, %0d returned", nt, nout);

        // Reset mid-flight: three requests dropped silently
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 8'h70 + i[7:0], 32'h0, 0, 0);
        idle(2, 0);
        step(0, 8'h0, 32'h0, 1, 1);
        chk("midrst_rvalid", {31'b0, s_rvalid}, 32'd0);
        chk("midrst_busy", {31'b0, s_busy}, 32'd0);
        chk("midrst_ready", {31'b0, s_ready}, 32'd0);
        chk("midrst_en", {31'b0, s_en}, 32'd0);
        step(0, 8'h0, 32'h0, 1, 1);
        step(0, 8'h0, 32'h0, 1, 0);
        step(0, 8'h0, 32'h0, 1, 0);
        chk("postrst_ready", {31'b0, s_ready}, 32'd1);
        chk("postrst_en", {31'b0, s_en}, 32'd1);
        nout = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 8'h0, 32'h77770000 + i, 1, 0);
            if (s_rvalid) nout++;
        end
        chk("postrst_no_rsp", nout, 0);
        $display("mid-reset: %0d stale responses", nout);

        // Tail write and pop in the same cycle at occupancy 1
        do_reset();
        step(1, 8'hA1, 32'h0, 0, 0);
        step(1, 8'hB2, 32'h0, 0, 0);
        idle(8, 0);
        step(0, 8'h0, 32'h11110000, 0, 0);          // cycle 10
        step(0, 8'h0, 32'h22220000, 1, 0);          // cycle 11
        chk("wp_head0_tag", {24'b0, s_tag}, 32'hA1);
        chk("wp_head0_data", s_data, 32'h11110000);
        step(0, 8'h0, 32'h0, 0, 0);                 // cycle 12
        chk("wp_rvalid", {31'b0, s_rvalid}, 32'd1);
        chk("wp_head1_tag", {24'b0, s_tag}, 32'hB2);
        chk("wp_head1_data", s_data, 32'h22220000);
        step(0, 8'h0, 32'h0, 1, 0);
        step(0, 8'h0, 32'h0, 0, 0);
        chk("wp_busy_done", {31'b0, s_busy}, 32'd0);
        $display("write+pop: head tag=%h", s_tag);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
        end
        $display("random: 800 cycles done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
